ps2_key_decoder: RTL and testbench

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

---
 rtl/ps2_pkg.sv | 99 +++++++++
 rtl/ps2_event_fifo.sv | 63 ++++++
 rtl/ps2_key_decoder.sv | 121 ++++++++++++
 tb/tb_ps2_key_decoder.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 set-2 decoder definitions: scan codes, prefix FSM states, event layout, ASCII map.
package ps2_pkg;

  localparam logic [7:0] SC_EXT      = 8'hE0;
  localparam logic [7:0] SC_BRK      = 8'hF0;
  localparam logic [7:0] SC_LSHIFT   = 8'h12;
  localparam logic [7:0] SC_RSHIFT   = 8'h59;
  localparam logic [7:0] SC_CTRL     = 8'h14;
  localparam logic [7:0] SC_ALT      = 8'h11;
  localparam logic [7:0] SC_CAPS     = 8'h58;
  localparam logic [7:0] SC_KP_SLASH = 8'h4A;
  localparam logic [7:0] SC_ENTER    = 8'h5A;

  typedef enum logic [1:0] {ST_IDLE, ST_EXT, ST_BRK, ST_EXT_BRK} ps2_state_t;

  localparam int unsigned EV_ASCII_LSB = 0;
  localparam int unsigned EV_CODE_LSB  = 8;
  localparam int unsigned EV_EXT_BIT   = 16;
  localparam int unsigned EV_BRK_BIT   = 17;
  localparam int unsigned EV_SHIFT_BIT = 18;
  localparam int unsigned EV_CTRL_BIT  = 19;
  localparam int unsigned EV_ALT_BIT   = 20;
  localparam int unsigned EV_CAPS_BIT  = 21;
  localparam int unsigned EV_W         = 22;

  // Field order matches the bit positions above (MSB first).
  typedef struct packed {
    logic       caps;
    logic       alt;
    logic       ctrl;
    logic       shift;
    logic       brk;
    logic       ext;
    logic [7:0] code;
    logic [7:0] ascii;
  } ps2_event_t;

  function automatic logic [7:0] letter_of(input logic [7:0] code);
    case (code)
      8'h1C: return 8'h61; 8'h32: return 8'h62; 8'h21: return 8'h63; 8'h23: return 8'h64;
      8'h24: return 8'h65; 8'h2B: return 8'h66; 8'h34: return 8'h67; 8'h33: return 8'h68;
      8'h43: return 8'h69; 8'h3B: return 8'h6A; 8'h42: return 8'h6B; 8'h4B: return 8'h6C;
      8'h3A: return 8'h6D; 8'h31: return 8'h6E; 8'h44: return 8'h6F; 8'h4D: return 8'h70;
      8'h15: return 8'h71; 8'h2D: return 8'h72; 8'h1B: return 8'h73; 8'h2C: return 8'h74;
      8'h3C: return 8'h75; 8'h2A: return 8'h76; 8'h1D: return 8'h77; 8'h22: return 8'h78;
      8'h35: return 8'h79; 8'h1A: return 8'h7A;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] symbol_of(input logic [7:0] code, input logic shift);
    case (code)
      8'h45: return shift ? 8'h29 : 8'h30;
      8'h16: return shift ? 8'h21 : 8'h31;
      8'h1E: return shift ? 8'h40 : 8'h32;
      8'h26: return shift ? 8'h23 : 8'h33;
      8'h25: return shift ? 8'h24 : 8'h34;
      8'h2E: return shift ? 8'h25 : 8'h35;
      8'h36: return shift ? 8'h5E : 8'h36;
      8'h3D: return shift ? 8'h26 : 8'h37;
      8'h3E: return shift ? 8'h2A : 8'h38;
      8'h46: return shift ? 8'h28 : 8'h39;
      8'h0E: return shift ? 8'h7E : 8'h60;
      8'h4E: return shift ? 8'h5F : 8'h2D;
      8'h55: return shift ? 8'h2B : 8'h3D;
      8'h54: return shift ? 8'h7B : 8'h5B;
      8'h5B: return shift ? 8'h7D : 8'h5D;
      8'h5D: return shift ? 8'h7C : 8'h5C;
      8'h4C: return shift ? 8'h3A : 8'h3B;
      8'h52: return shift ? 8'h22 : 8'h27;
      8'h41: return shift ? 8'h3C : 8'h2C;
      8'h49: return shift ? 8'h3E : 8'h2E;
      8'h4A: return shift ? 8'h3F : 8'h2F;
      8'h29: return 8'h20;
      8'h66: return 8'h08;
      8'h0D: return 8'h09;
      8'h5A: return 8'h0A;
      8'h76: return 8'h1B;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] ascii_of(input logic [7:0] code, input logic ext,
                                          input logic shift, input logic caps, input logic ctrl);
    logic [7:0] lc;
    lc = letter_of(code);
    if (ext) begin
      if (code == SC_KP_SLASH) return 8'h2F;
      if (code == SC_ENTER) return 8'h0A;
      return 8'h00;
    end
    if (lc != 8'h00) begin
      if (ctrl) return (lc - 8'h20) & 8'h1F;
      return (shift ^ caps) ? (lc - 8'h20) : lc;
    end
    return symbol_of(code, shift);
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Event FIFO with a registered head word, valid flag and drop-on-full overflow pulse.
module ps2_event_fifo #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned DATA_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic              valid,
  output logic [DATA_W-1:0] rdata,
  output logic              overflow
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     rd_ptr, wr_ptr, rd_next;
  logic [CW-1:0]     count, count_mid, count_next;
  logic [DATA_W-1:0] head_next;
  logic              full, do_pop, do_push;

  // A pop frees a slot in the same cycle, so a push into a full FIFO alongside a pop is accepted.
  always_comb begin
    full       = (count == CW'(FIFO_DEPTH));
    do_pop     = pop & valid;
    do_push    = push & (~full | do_pop);
    rd_next    = rd_ptr + AW'(do_pop);
    count_mid  = count - CW'(do_pop);
    count_next = count_mid + CW'(do_push);
    head_next  = '0;
    if (count_mid == '0) begin
      if (do_push) head_next = wdata;
    end else begin
      head_next = mem[rd_next];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      valid    <= 1'b0;
      rdata    <= '0;
      overflow <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr + AW'(do_push);
      rd_ptr   <= rd_next;
      count    <= count_next;
      valid    <= (count_next != '0);
      rdata    <= head_next;
      overflow <= push & full & ~do_pop;
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scan-code to key-event decoder feeding an event FIFO.
// Define PS2_BREAK_EVENT_EN to also enqueue events for non-modifier key releases.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned DATA_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scanDone,
  input  logic [7:0]        scanCode,
  output logic              outValid,
  input  logic              outReady,
  output logic [DATA_W-1:0] outData,
  output logic              overflow,
  output logic              capsLed
);

`ifdef PS2_BREAK_EVENT_EN
  localparam bit BREAK_EVENTS = 1'b1;
`else
  localparam bit BREAK_EVENTS = 1'b0;
`endif

  ps2_state_t       state;
  ps2_event_t       ev_q, ev_c;
  logic [EV_W-1:0]  ev_bits;
  logic             done_q, rise;
  logic             lshift, rshift, lctrl, rctrl, lalt, ralt, caps, caps_held;
  logic             push_q, is_ext, is_brk, is_mod, emit;

  // Decode the incoming byte against the modifier state as it stood before this byte.
  always_comb begin
    rise   = scanDone & ~done_q;
    is_ext = (state == ST_EXT) || (state == ST_EXT_BRK);
    is_brk = (state == ST_BRK) || (state == ST_EXT_BRK);
    is_mod = (scanCode == SC_LSHIFT) || (scanCode == SC_RSHIFT) || (scanCode == SC_CTRL) ||
             (scanCode == SC_ALT) || (!is_ext && scanCode == SC_CAPS);
    emit   = !is_mod && (!is_brk || BREAK_EVENTS);
    ev_c.caps  = caps;
    ev_c.alt   = lalt | ralt;
    ev_c.ctrl  = lctrl | rctrl;
    ev_c.shift = lshift | rshift;
    ev_c.brk   = is_brk;
    ev_c.ext   = is_ext;
    ev_c.code  = scanCode;
    ev_c.ascii = ascii_of(scanCode, is_ext, lshift | rshift, caps, lctrl | rctrl);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      done_q    <= 1'b0;
      lshift    <= 1'b0;
      rshift    <= 1'b0;
      lctrl     <= 1'b0;
      rctrl     <= 1'b0;
      lalt      <= 1'b0;
      ralt      <= 1'b0;
      caps      <= 1'b0;
      caps_held <= 1'b0;
      push_q    <= 1'b0;
      ev_q      <= '0;
    end else begin
      done_q <= scanDone;
      push_q <= 1'b0;
      if (rise) begin
        if (scanCode == SC_EXT) begin
          state <= ST_EXT;
        end else if (scanCode == SC_BRK && state == ST_IDLE) begin
          state <= ST_BRK;
        end else if (scanCode == SC_BRK && state == ST_EXT) begin
          state <= ST_EXT_BRK;
        end else begin
          state <= ST_IDLE;
          // E0 12 / E0 59 are fake shifts and fall through untouched.
          case (scanCode)
            SC_LSHIFT: if (!is_ext) lshift <= !is_brk;
            SC_RSHIFT: if (!is_ext) rshift <= !is_brk;
            SC_CTRL:   if (is_ext) rctrl <= !is_brk; else lctrl <= !is_brk;
            SC_ALT:    if (is_ext) ralt <= !is_brk; else lalt <= !is_brk;
            SC_CAPS: begin
              if (!is_ext) begin
                if (is_brk) begin
                  caps_held <= 1'b0;
                end else begin
                  caps_held <= 1'b1;
                  if (!caps_held) caps <= ~caps;
                end
              end
            end
            default: ;
          endcase
          if (emit) begin
            push_q <= 1'b1;
            ev_q   <= ev_c;
          end
        end
      end
    end
  end

  assign ev_bits = ev_q;
  assign capsLed = caps;

  ps2_event_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .DATA_W    (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push_q),
    .wdata   (DATA_W'(ev_bits)),
    .pop     (outReady),
    .valid   (outValid),
    .rdata   (outData),
    .overflow(overflow)
  );

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: table of scan sequences plus FIFO, latency and reset corners.
module tb_ps2_key_decoder;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned DW    = 32;

`ifdef PS2_BREAK_EVENT_EN
  localparam bit BRK_EV = 1'b1;
`else
  localparam bit BRK_EV = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, scanDone, outReady, outValid, overflow, capsLed;
  logic [7:0]    scanCode;
  logic [DW-1:0] outData;

  int errors = 0;
  int checks = 0;
  int ovf_cnt = 0;

  ps2_key_decoder #(.FIFO_DEPTH(DEPTH), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .scanDone(scanDone), .scanCode(scanCode),
    .outValid(outValid), .outReady(outReady), .outData(outData),
    .overflow(overflow), .capsLed(capsLed)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (overflow === 1'b1) ovf_cnt <= ovf_cnt + 1;

  typedef struct {
    logic [31:0] seq;
    int          n;
    bit          ev;
    logic [31:0] exp;
    bit          caps;
  } vec_t;

  vec_t vecs[$];

  // flags = {caps, alt, ctrl, shift, brk, ext}
  function automatic logic [31:0] mk(input logic [7:0] a, input logic [7:0] c, input logic [5:0] f);
    return {10'b0, f, c, a};
  endfunction

  function automatic vec_t row(input logic [31:0] s, input int n, input bit ev,
                               input logic [31:0] e, input bit cp);
    vec_t v;
    v.seq = s; v.n = n; v.ev = ev; v.exp = e; v.caps = cp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] code, input int hold);
    @(negedge clk);
    scanCode = code;
    scanDone = 1'b1;
    repeat (hold) @(negedge clk);
    scanDone = 1'b0;
    @(negedge clk);
  endtask

  task automatic pop_one();
    @(negedge clk);
    outReady = 1'b1;
    @(negedge clk);
    outReady = 1'b0;
  endtask

  logic [7:0] keys [9];
  logic [7:0] b;
  int         ovf0;
  logic [31:0] held;

  initial begin
    keys = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43};

    vecs.push_back(row(32'h1C000000, 1, 1, mk(8'h61, 8'h1C, 6'b000000), 0));
    vecs.push_back(row(32'hF01C0000, 2, BRK_EV, mk(8'h61, 8'h1C, 6'b000010), 0));
    vecs.push_back(row(32'h59000000, 1, 0, 0, 0));
    vecs.push_back(row(32'h1C000000, 1, 1, mk(8'h41, 8'h1C, 6'b000100), 0));
    vecs.push_back(row(32'hF0590000, 2, 0, 0, 0));
    vecs.push_back(row(32'h1C000000, 1, 1, mk(8'h61, 8'h1C, 6'b000000), 0));
    vecs.push_back(row(32'h58000000, 1, 0, 0, 1));
    vecs.push_back(row(32'h58000000, 1, 0, 0, 1));
    vecs.push_back(row(32'hF0580000, 2, 0, 0, 1));
    vecs.push_back(row(32'h1C000000, 1, 1, mk(8'h41, 8'h1C, 6'b100000), 1));
    vecs.push_back(row(32'h12000000, 1, 0, 0, 1));
    vecs.push_back(row(32'h1C000000, 1, 1, mk(8'h61, 8'h1C, 6'b100100), 1));
    vecs.push_back(row(32'h16000000, 1, 1, mk(8'h21, 8'h16, 6'b100100), 1));
    vecs.push_back(row(32'hF0120000, 2, 0, 0, 1));
    vecs.push_back(row(32'h58000000, 1, 0, 0, 0));
    vecs.push_back(row(32'hF0580000, 2, 0, 0, 0));
    vecs.push_back(row(32'hE0120000, 2, 0, 0, 0));
    vecs.push_back(row(32'h1C000000, 1, 1, mk(8'h61, 8'h1C, 6'b000000), 0));
    vecs.push_back(row(32'hE0F01200, 3, 0, 0, 0));
    vecs.push_back(row(32'hE05A0000, 2, 1, mk(8'h0A, 8'h5A, 6'b000001), 0));
    vecs.push_back(row(32'hE04A0000, 2, 1, mk(8'h2F, 8'h4A, 6'b000001), 0));
    vecs.push_back(row(32'h14000000, 1, 0, 0, 0));
    vecs.push_back(row(32'h21000000, 1, 1, mk(8'h03, 8'h21, 6'b001000), 0));
    vecs.push_back(row(32'h16000000, 1, 1, mk(8'h31, 8'h16, 6'b001000), 0));
    vecs.push_back(row(32'hF0140000, 2, 0, 0, 0));
    vecs.push_back(row(32'h12000000, 1, 0, 0, 0));
    vecs.push_back(row(32'h0E000000, 1, 1, mk(8'h7E, 8'h0E, 6'b000100), 0));
    vecs.push_back(row(32'h4E000000, 1, 1, mk(8'h5F, 8'h4E, 6'b000100), 0));
    vecs.push_back(row(32'hF0120000, 2, 0, 0, 0));
    vecs.push_back(row(32'h29000000, 1, 1, mk(8'h20, 8'h29, 6'b000000), 0));
    vecs.push_back(row(32'h66000000, 1, 1, mk(8'h08, 8'h66, 6'b000000), 0));
    vecs.push_back(row(32'h76000000, 1, 1, mk(8'h1B, 8'h76, 6'b000000), 0));
    vecs.push_back(row(32'h0D000000, 1, 1, mk(8'h09, 8'h0D, 6'b000000), 0));
    vecs.push_back(row(32'hE0750000, 2, 1, mk(8'h00, 8'h75, 6'b000001), 0));
    vecs.push_back(row(32'h07000000, 1, 1, mk(8'h00, 8'h07, 6'b000000), 0));
    vecs.push_back(row(32'hE0110000, 2, 0, 0, 0));
    vecs.push_back(row(32'h1C000000, 1, 1, mk(8'h61, 8'h1C, 6'b010000), 0));
    vecs.push_back(row(32'hE0F01100, 3, 0, 0, 0));
    vecs.push_back(row(32'h1C000000, 1, 1, mk(8'h61, 8'h1C, 6'b000000), 0));
    vecs.push_back(row(32'hE0F0E05A, 4, 1, mk(8'h0A, 8'h5A, 6'b000001), 0));
    vecs.push_back(row(32'hE0140000, 2, 0, 0, 0));
    vecs.push_back(row(32'h1A000000, 1, 1, mk(8'h1A, 8'h1A, 6'b001000), 0));
    vecs.push_back(row(32'hE0F01400, 3, 0, 0, 0));

    reset = 1'b1; scanDone = 1'b0; scanCode = 8'h00; outReady = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_valid", 32'(outValid), 32'd0);
    chk("reset_data", outData, 32'd0);
    chk("reset_ovf", 32'(overflow), 32'd0);
    chk("reset_caps", 32'(capsLed), 32'd0);

    foreach (vecs[i]) begin
      for (int j = 0; j < vecs[i].n; j++) begin
        held = vecs[i].seq;
        b = held[31-8*j -: 8];
        send(b, 2);
      end
      if (vecs[i].ev) begin
        chk($sformatf("row%0d_valid", i), 32'(outValid), 32'd1);
        chk($sformatf("row%0d_data", i), outData, vecs[i].exp);
        pop_one();
      end
      chk($sformatf("row%0d_empty", i), 32'(outValid), 32'd0);
      chk($sformatf("row%0d_caps", i), 32'(capsLed), 32'(vecs[i].caps));
    end

    // Latency from the scanDone rise, then a long level must not produce a second event.
    @(negedge clk);
    scanCode = 8'h1C; scanDone = 1'b1;
    @(negedge clk);
    chk("lat_edge_k", 32'(outValid), 32'd0);
    @(negedge clk);
    chk("lat_edge_k1", 32'(outValid), 32'd1);
    chk("lat_data", outData, mk(8'h61, 8'h1C, 6'b0));
    repeat (4) @(negedge clk);
    chk("stable_data", outData, mk(8'h61, 8'h1C, 6'b0));
    scanDone = 1'b0;
    @(negedge clk);
    pop_one();
    chk("level_single", 32'(outValid), 32'd0);

    // Overflow: DEPTH+1 keys with no consumer.
    ovf0 = ovf_cnt;
    for (int i = 0; i <= DEPTH; i++) send(keys[i], 2);
    chk("ovf_valid", 32'(outValid), 32'd1);
    chk("ovf_pulses", 32'(ovf_cnt - ovf0), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("ovf_drain%0d", i), outData, mk(8'h61 + 8'(i), keys[i], 6'b0));
      pop_one();
    end
    chk("ovf_empty", 32'(outValid), 32'd0);

    // Push and pop on the same edge while full: no drop.
    for (int i = 0; i < DEPTH; i++) send(keys[i], 2);
    ovf0 = ovf_cnt;
    @(negedge clk);
    scanCode = keys[DEPTH]; scanDone = 1'b1;
    @(negedge clk);
    outReady = 1'b1;
    @(negedge clk);
    outReady = 1'b0; scanDone = 1'b0;
    repeat (2) @(negedge clk);
    chk("full_pp_ovf", 32'(ovf_cnt - ovf0), 32'd0);
    for (int i = 1; i <= DEPTH; i++) begin
      chk($sformatf("full_pp_drain%0d", i), outData, mk(8'h61 + 8'(i), keys[i], 6'b0));
      pop_one();
    end
    chk("full_pp_empty", 32'(outValid), 32'd0);

    // Reset in the middle of E0 F0 with Caps Lock on.
    send(8'h58, 2);
    send(8'hE0, 2);
    send(8'hF0, 2);
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    chk("midrst_caps", 32'(capsLed), 32'd0);
    chk("midrst_valid", 32'(outValid), 32'd0);
    chk("midrst_data", outData, 32'd0);
    send(8'h1C, 2);
    chk("midrst_ev_valid", 32'(outValid), 32'd1);
    chk("midrst_ev_data", outData, mk(8'h61, 8'h1C, 6'b0));
    pop_one();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
